// File: rtl/gci_std_display_char_writer.sv
// gci_std_display_char_writer: FIFO-buffered character writer for the GCI display text plane.
// Define GCI_STD_DISPLAY_CHAR_WRITER_CTRL_EN to decode LF/CR/BS as cursor moves instead of glyphs.
module gci_std_display_char_writer #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 34,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] CLEAR_ADDR = 32'h0000C000
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iCHAR_REQ,
  output logic        oCHAR_BUSY,
  input  logic [7:0]  iCHAR_DATA,
  input  logic [23:0] iCHAR_COLOR,
  input  logic        iCLEAR_REQ,
  input  logic [15:0] iCLEAR_COLOR,
  output logic        oDEV_REQ,
  input  logic        iDEV_BUSY,
  output logic        oDEV_RW,
  output logic [31:0] oDEV_ADDR,
  output logic [31:0] oDEV_DATA,
  input  logic        iDEV_REQ,
  output logic        oDEV_BUSY,
  output logic [5:0]  oCURSOR_ROW,
  output logic [6:0]  oCURSOR_COL,
  output logic        oIDLE
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;
  state_t r_state, w_next;
  logic [31:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic r_clr_pend, r_is_clr;
  logic [15:0] r_clr_color;
  logic [31:0] r_addr, r_data;
  logic [5:0] r_row;
  logic [6:0] r_col;
  logic [31:0] w_head, w_char_addr, w_char_data;
  logic [5:0] w_row_inc;
  logic w_push, w_pop, w_ctrl, w_accept, w_rsp;
  assign w_head      = r_mem[r_rp];
  assign w_push      = iCHAR_REQ && !oCHAR_BUSY;
  assign w_pop       = r_state == IDLE && !r_clr_pend && r_cnt != '0;
  assign w_accept    = r_state == ISSUE && !iDEV_BUSY;
  assign w_rsp       = r_state == WAIT_RSP && iDEV_REQ;
  assign w_row_inc   = r_row == 6'(ROWS - 1) ? '0 : r_row + 6'd1;
  assign w_char_addr = ((32'(r_row) + 32'd1) << 10) + (32'(r_col) << 2);
  // bit 7 of the code is dropped: the text plane holds 7-bit glyph codes
  assign w_char_data = {w_head[31:8], w_head[7:0] & 8'h7F};
`ifdef GCI_STD_DISPLAY_CHAR_WRITER_CTRL_EN
  assign w_ctrl = w_head[7:0] == 8'h0A || w_head[7:0] == 8'h0D || w_head[7:0] == 8'h08;
`else
  assign w_ctrl = 1'b0;
`endif
  always_ff @(posedge iCLOCK)
    if (w_push) r_mem[r_wp] <= {iCHAR_COLOR, iCHAR_DATA};
  always_ff @(posedge iCLOCK or negedge inRESET)
    if (!inRESET) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge iCLOCK or negedge inRESET)
    if (!inRESET) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && (r_clr_pend || (w_pop && !w_ctrl))) w_next = ISSUE;
    if (w_accept) w_next = WAIT_RSP;
    if (w_rsp) w_next = IDLE;
  end
  always_comb begin
    oDEV_REQ    = r_state == ISSUE;
    oDEV_RW     = r_state == ISSUE;
    oDEV_ADDR   = r_addr;
    oDEV_DATA   = r_data;
    oDEV_BUSY   = 1'b0;
    oCHAR_BUSY  = r_cnt == (AW+1)'(FIFO_DEPTH);
    oCURSOR_ROW = r_row;
    oCURSOR_COL = r_col;
    oIDLE       = r_state == IDLE && !r_clr_pend && r_cnt == '0;
  end
  always_ff @(posedge iCLOCK or negedge inRESET)
    if (!inRESET) begin
      r_addr      <= '0;
      r_data      <= '0;
      r_is_clr    <= 1'b0;
      r_clr_pend  <= 1'b0;
      r_clr_color <= '0;
      r_row       <= '0;
      r_col       <= '0;
    end else begin
      // a new pulse wins over the acceptance of the clear already in flight
      if (iCLEAR_REQ) begin
        r_clr_pend  <= 1'b1;
        r_clr_color <= iCLEAR_COLOR;
      end else if (w_accept && r_is_clr) r_clr_pend <= 1'b0;
      if (r_state == IDLE && r_clr_pend) begin
        r_addr   <= CLEAR_ADDR;
        r_data   <= {16'h0, r_clr_color};
        r_is_clr <= 1'b1;
      end else if (w_pop && !w_ctrl) begin
        r_addr   <= w_char_addr;
        r_data   <= w_char_data;
        r_is_clr <= 1'b0;
      end
      if (w_rsp) begin
        r_row <= r_is_clr ? '0 : r_col == 7'(COLS - 1) ? w_row_inc : r_row;
        r_col <= r_is_clr || r_col == 7'(COLS - 1) ? '0 : r_col + 7'd1;
      end
`ifdef GCI_STD_DISPLAY_CHAR_WRITER_CTRL_EN
      else if (w_pop && w_ctrl) begin
        r_row <= w_head[7:0] == 8'h0A ? w_row_inc : r_row;
        r_col <= w_head[7:0] != 8'h08 ? '0 : r_col != '0 ? r_col - 7'd1 : r_col;
      end
`endif
    end
endmodule

// File: tb/tb_gci_std_display_char_writer.sv
// tb_gci_std_display_char_writer: randomized bench against a cursor-position reference model.
`timescale 1ns/1ps
module tb_gci_std_display_char_writer;
  localparam int COLS = 80, ROWS = 34;
  logic iCLOCK = 0, inRESET = 0, iCHAR_REQ = 0, iCLEAR_REQ = 0, iDEV_BUSY = 0, iDEV_REQ = 0;
  logic [7:0] iCHAR_DATA = 0;
  logic [23:0] iCHAR_COLOR = 0;
  logic [15:0] iCLEAR_COLOR = 0;
  logic oCHAR_BUSY, oDEV_REQ, oDEV_RW, oDEV_BUSY, oIDLE;
  logic [31:0] oDEV_ADDR, oDEV_DATA;
  logic [5:0] oCURSOR_ROW;
  logic [6:0] oCURSOR_COL;
  int n_cmp = 0, n_bad = 0, pos = 0;
  logic [64:0] obs_q[$], exp_q[$];
  logic rsp_pend = 0;

  always #5 iCLOCK = ~iCLOCK;

  gci_std_display_char_writer dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iCHAR_REQ(iCHAR_REQ), .oCHAR_BUSY(oCHAR_BUSY),
    .iCHAR_DATA(iCHAR_DATA), .iCHAR_COLOR(iCHAR_COLOR), .iCLEAR_REQ(iCLEAR_REQ),
    .iCLEAR_COLOR(iCLEAR_COLOR), .oDEV_REQ(oDEV_REQ), .iDEV_BUSY(iDEV_BUSY), .oDEV_RW(oDEV_RW),
    .oDEV_ADDR(oDEV_ADDR), .oDEV_DATA(oDEV_DATA), .iDEV_REQ(iDEV_REQ), .oDEV_BUSY(oDEV_BUSY),
    .oCURSOR_ROW(oCURSOR_ROW), .oCURSOR_COL(oCURSOR_COL), .oIDLE(oIDLE)
  );

  // device model: log each accepted write, answer one cycle later
  initial forever @(negedge iCLOCK) begin
    iDEV_REQ = rsp_pend;
    rsp_pend = oDEV_REQ && !iDEV_BUSY && inRESET;
    if (rsp_pend) obs_q.push_back({oDEV_RW, oDEV_ADDR, oDEV_DATA});
  end

  task automatic m_char(input logic [7:0] c, input logic [23:0] col);
    exp_q.push_back({1'b1, 32'(32'h400 * (pos / COLS + 1) + 4 * (pos % COLS)), col, 1'b0, c[6:0]});
    pos = (pos + 1) % (COLS * ROWS);
  endtask

  task automatic m_clear(input logic [15:0] color);
    exp_q.push_back({1'b1, 32'h0000C000, 16'h0, color});
    pos = 0;
  endtask

  task automatic push(input logic [7:0] c, input logic [23:0] col);
    iCHAR_REQ = 1; iCHAR_DATA = c; iCHAR_COLOR = col;
    @(posedge iCLOCK); #1;
    iCHAR_REQ = 0;
  endtask

  task automatic clear_pulse(input logic [15:0] color);
    iCLEAR_REQ = 1; iCLEAR_COLOR = color;
    @(posedge iCLOCK); #1;
    iCLEAR_REQ = 0;
  endtask

  task automatic wait_idle(input bit rnd);
    int k = 0;
    while (!oIDLE && k < 500) begin
      if (rnd) iDEV_BUSY = 1'($urandom_range(0, 1));
      @(posedge iCLOCK); #1;
      k++;
    end
    iDEV_BUSY = 0;
    n_cmp++;
    if (!oIDLE) begin n_bad++; $display("FAIL idle_timeout: oIDLE=%b after %0d cycles, want 1", oIDLE, k); end
    repeat (2) @(posedge iCLOCK);
    #1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge iCLOCK);
    #1;
    n_cmp++;
    if ({oDEV_REQ, oDEV_RW, oDEV_BUSY, oCHAR_BUSY, oIDLE} !== 5'b00001) begin
      n_bad++; $display("FAIL reset_flags: got %b want 00001", {oDEV_REQ, oDEV_RW, oDEV_BUSY, oCHAR_BUSY, oIDLE});
    end
    n_cmp++;
    if ({oDEV_ADDR, oDEV_DATA, oCURSOR_ROW, oCURSOR_COL} !== '0) begin
      n_bad++; $display("FAIL reset_regs: got addr=%h data=%h row=%0d col=%0d want all 0", oDEV_ADDR, oDEV_DATA, oCURSOR_ROW, oCURSOR_COL);
    end
    inRESET = 1;
    @(posedge iCLOCK); #1;
    n_cmp++;
    if (oIDLE !== 1'b1 || oDEV_REQ !== 1'b0) begin n_bad++; $display("FAIL reset_release: got idle=%b req=%b want 1 0", oIDLE, oDEV_REQ); end
  endtask

  task automatic test_single;
    logic [64:0] o, e;
    m_char(8'h41, 24'hFFF000);
    push(8'h41, 24'hFFF000);
    wait_idle(0);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL single_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL single_write: got rw=%b addr=%h data=%h want rw=%b addr=%h data=%h", o[64], o[63:32], o[31:0], e[64], e[63:32], e[31:0]); end
    end
    obs_q.delete(); exp_q.delete();
    n_cmp++;
    if ({oCURSOR_ROW, oCURSOR_COL} !== {6'd0, 7'd1}) begin n_bad++; $display("FAIL single_cursor: got (%0d,%0d) want (0,1)", oCURSOR_ROW, oCURSOR_COL); end
  endtask

  task automatic test_wrap;
    logic [64:0] o, e;
    logic [7:0] c;
    logic [23:0] col;
    int j = 0;
    for (int i = 0; i < 80; i++) begin
      c = 8'($urandom_range(32, 255)); col = 24'($urandom);
      m_char(c, col); push(c, col);
      if (i % 16 == 15) wait_idle(0);
    end
    wait_idle(0);
    n_cmp++;
    if (exp_q.size() != 80 || obs_q.size() != 80 || obs_q[79][63:32] !== 32'h800) begin
      n_bad++; $display("FAIL wrap_line: got %0d writes, last addr=%h want 80 writes, last addr 00000800", obs_q.size(), obs_q.size() > 0 ? obs_q[$][63:32] : 32'hx);
    end
    n_cmp++;
    if ({oCURSOR_ROW, oCURSOR_COL} !== {6'd1, 7'd1}) begin n_bad++; $display("FAIL wrap_cursor1: got (%0d,%0d) want (1,1)", oCURSOR_ROW, oCURSOR_COL); end
    while (pos != COLS * ROWS - 1) begin
      c = 8'($urandom_range(32, 255)); col = 24'($urandom);
      m_char(c, col); push(c, col);
      j++;
      if (j % 16 == 0) wait_idle(0);
    end
    wait_idle(0);
    n_cmp++;
    if ({oCURSOR_ROW, oCURSOR_COL} !== {6'd33, 7'd79}) begin n_bad++; $display("FAIL wrap_cursor_end: got (%0d,%0d) want (33,79)", oCURSOR_ROW, oCURSOR_COL); end
    m_char(8'h5A, 24'h123456); push(8'h5A, 24'h123456);
    wait_idle(0);
    n_cmp++;
    if ({oCURSOR_ROW, oCURSOR_COL} !== {6'd0, 7'd0}) begin n_bad++; $display("FAIL wrap_cursor_home: got (%0d,%0d) want (0,0)", oCURSOR_ROW, oCURSOR_COL); end
    m_char(8'h21, 24'h654321); push(8'h21, 24'h654321);
    wait_idle(0);
    n_cmp++;
    if (obs_q.size() == 0 || obs_q[$][63:32] !== 32'h400) begin n_bad++; $display("FAIL wrap_screen: got last addr=%h want 00000400", obs_q.size() > 0 ? obs_q[$][63:32] : 32'hx); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL wrap_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL wrap_write: got rw=%b addr=%h data=%h want rw=%b addr=%h data=%h", o[64], o[63:32], o[31:0], e[64], e[63:32], e[31:0]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_busy_hold;
    logic [64:0] o, e;
    logic [7:0] c = 8'($urandom_range(32, 255));
    logic [23:0] col = 24'($urandom);
    int k = 0;
    iDEV_BUSY = 1;
    m_char(c, col); push(c, col);
    while (!oDEV_REQ && k < 20) begin @(posedge iCLOCK); #1; k++; end
    e = exp_q[0];
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({oDEV_REQ, oDEV_RW, oDEV_ADDR, oDEV_DATA} !== {2'b11, e[63:0]}) begin
        n_bad++; $display("FAIL busy_hold_%0d: got req=%b addr=%h data=%h want req=1 addr=%h data=%h", i, oDEV_REQ, oDEV_ADDR, oDEV_DATA, e[63:32], e[31:0]);
      end
      @(posedge iCLOCK); #1;
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_bad++; $display("FAIL busy_hold_early: got %0d writes while busy want 0", obs_q.size()); end
    iDEV_BUSY = 0;
    wait_idle(0);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL busy_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL busy_write: got rw=%b addr=%h data=%h want rw=%b addr=%h data=%h", o[64], o[63:32], o[31:0], e[64], e[63:32], e[31:0]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow;
    logic [64:0] o, e;
    logic [7:0] c;
    logic [23:0] col;
    int k = 0;
    iDEV_BUSY = 1;
    c = 8'($urandom_range(32, 255)); col = 24'($urandom);
    m_char(c, col); push(c, col);
    while (!oDEV_REQ && k < 20) begin @(posedge iCLOCK); #1; k++; end
    for (int i = 1; i <= 20; i++) begin
      c = 8'($urandom_range(32, 255)); col = 24'($urandom);
      if (i <= 16) m_char(c, col);
      iCHAR_REQ = 1; iCHAR_DATA = c; iCHAR_COLOR = col;
      @(posedge iCLOCK); #1;
      n_cmp++;
      if (oCHAR_BUSY !== (i >= 16)) begin n_bad++; $display("FAIL overflow_busy_%0d: got %b want %b", i, oCHAR_BUSY, i >= 16); end
    end
    iCHAR_REQ = 0;
    iDEV_BUSY = 0;
    wait_idle(0);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL overflow_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL overflow_write: got rw=%b addr=%h data=%h want rw=%b addr=%h data=%h", o[64], o[63:32], o[31:0], e[64], e[63:32], e[31:0]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_clear;
    logic [64:0] o, e;
    logic [7:0] c = 8'($urandom_range(32, 255));
    logic [23:0] col = 24'($urandom);
    int k = 0;
    m_clear(16'hF800); m_char(8'h43, 24'h0F00F0);
    iCLEAR_REQ = 1; iCLEAR_COLOR = 16'hF800;
    push(8'h43, 24'h0F00F0);
    iCLEAR_REQ = 0;
    wait_idle(0);
    iDEV_BUSY = 1;
    m_char(c, col); push(c, col);
    while (!oDEV_REQ && k < 20) begin @(posedge iCLOCK); #1; k++; end
    clear_pulse(16'h1234);
    clear_pulse(16'h07E0);
    m_clear(16'h07E0);
    iDEV_BUSY = 0;
    wait_idle(0);
    n_cmp++;
    if ({oCURSOR_ROW, oCURSOR_COL} !== 13'd0) begin n_bad++; $display("FAIL clear_cursor: got (%0d,%0d) want (0,0)", oCURSOR_ROW, oCURSOR_COL); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL clear_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL clear_write: got rw=%b addr=%h data=%h want rw=%b addr=%h data=%h", o[64], o[63:32], o[31:0], e[64], e[63:32], e[31:0]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_ctrl;
    logic [64:0] o, e;
    clear_pulse(16'h0001);
    m_clear(16'h0001);
    wait_idle(0);
    obs_q.delete(); exp_q.delete();
    m_char(8'h58, 24'hABC123);
`ifdef GCI_STD_DISPLAY_CHAR_WRITER_CTRL_EN
    pos = ((pos / COLS + 1) % ROWS) * COLS;
`else
    m_char(8'h0A, 24'hABC123);
`endif
    m_char(8'h59, 24'hABC123);
    push(8'h58, 24'hABC123); push(8'h0A, 24'hABC123); push(8'h59, 24'hABC123);
    wait_idle(0);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL ctrl_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL ctrl_write: got rw=%b addr=%h data=%h want rw=%b addr=%h data=%h", o[64], o[63:32], o[31:0], e[64], e[63:32], e[31:0]); end
    end
    obs_q.delete(); exp_q.delete();
    n_cmp++;
    if ({oCURSOR_ROW, oCURSOR_COL} !== {6'(pos / COLS), 7'(pos % COLS)}) begin
      n_bad++; $display("FAIL ctrl_cursor: got (%0d,%0d) want (%0d,%0d)", oCURSOR_ROW, oCURSOR_COL, pos / COLS, pos % COLS);
    end
  endtask

  task automatic test_random;
    logic [64:0] o, e;
    logic [7:0] c;
    logic [23:0] col;
    logic [15:0] cc;
    for (int b = 0; b < 8; b++) begin
      int n = $urandom_range(1, 16);
      bit with_clr = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        c = 8'($urandom_range(32, 255)); col = 24'($urandom); cc = 16'($urandom);
        if (i == 0 && with_clr) begin m_clear(cc); iCLEAR_REQ = 1; iCLEAR_COLOR = cc; end
        m_char(c, col);
        iDEV_BUSY = 1'($urandom_range(0, 1));
        push(c, col);
        iCLEAR_REQ = 0;
      end
      wait_idle(1);
      n_cmp++;
      if ({oCURSOR_ROW, oCURSOR_COL} !== {6'(pos / COLS), 7'(pos % COLS)}) begin
        n_bad++; $display("FAIL rand_cursor: got (%0d,%0d) want (%0d,%0d)", oCURSOR_ROW, oCURSOR_COL, pos / COLS, pos % COLS);
      end
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rand_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL rand_write: got rw=%b addr=%h data=%h want rw=%b addr=%h data=%h", o[64], o[63:32], o[31:0], e[64], e[63:32], e[31:0]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_abort;
    logic [64:0] o, e;
    int k = 0;
    iDEV_BUSY = 1;
    push(8'h41, 24'h111111); push(8'h42, 24'h222222); push(8'h43, 24'h333333);
    while (!oDEV_REQ && k < 20) begin @(posedge iCLOCK); #1; k++; end
    inRESET = 0;
    #1;
    n_cmp++;
    if ({oDEV_REQ, oIDLE, oCHAR_BUSY} !== 3'b010) begin n_bad++; $display("FAIL abort_flags: got req/idle/busy=%b want 010", {oDEV_REQ, oIDLE, oCHAR_BUSY}); end
    @(posedge iCLOCK); #1;
    inRESET = 1;
    iDEV_BUSY = 0;
    pos = 0;
    repeat (5) @(posedge iCLOCK);
    #1;
    n_cmp++;
    if (obs_q.size() != 0 || oIDLE !== 1'b1) begin n_bad++; $display("FAIL abort_lost: got %0d writes idle=%b want 0 writes idle=1", obs_q.size(), oIDLE); end
    obs_q.delete(); exp_q.delete();
    m_char(8'h44, 24'h444444); push(8'h44, 24'h444444);
    wait_idle(0);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL abort_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL abort_write: got rw=%b addr=%h data=%h want rw=%b addr=%h data=%h", o[64], o[63:32], o[31:0], e[64], e[63:32], e[31:0]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset;
    test_single;
    test_wrap;
    test_busy_hold;
    test_overflow;
    test_clear;
    test_ctrl;
    test_random;
    test_reset_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
